puf_key_collector: RTL and testbench

- Downstream consumer of the ring-oscillator PUF generator. Sequences challenges into it, times each measurement window and samples its 1-bit response.
- Each key bit is measured VOTES times and resolved by majority vote; resolved bits are assembled into a KEY_BITS-wide key.
- Key is presented to the root-of-trust key logic with a level valid flag.

---
 rtl/puf_key_collector.sv | 159 +++++++++++++++
 tb/tb_puf_key_collector.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/puf_key_collector.sv
// Purpose: drives the RO-PUF through challenges, majority-votes repeated samples per bit and assembles a key.
// Latency: key_valid rises 1 + KEY_BITS*(VOTES*(MEAS_CYCLES+2)+1) cycles after the accepted start edge.
// Backpressure: none; start is ignored while busy, key and key_valid hold until the next accepted start.
module puf_key_collector #(
  parameter int KEY_BITS    = 16,
  parameter int MEAS_CYCLES = 256,
  parameter int VOTES       = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                puf_response,
  output logic                puf_enable,
  output logic [1:0]          puf_challenge,
  output logic                busy,
  output logic                key_valid,
  output logic [KEY_BITS-1:0] key
);

  localparam int BIT_W  = (KEY_BITS > 1) ? $clog2(KEY_BITS) : 1;
  localparam int MEAS_W = $clog2(MEAS_CYCLES);
  localparam int VOTE_W = (VOTES > 1) ? $clog2(VOTES) : 1;
  localparam int ONES_W = $clog2(VOTES + 1);

  localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(KEY_BITS - 1);
  localparam logic [MEAS_W-1:0] LAST_MEAS = MEAS_W'(MEAS_CYCLES - 1);
  localparam logic [VOTE_W-1:0] LAST_VOTE = VOTE_W'(VOTES - 1);
  localparam logic [ONES_W-1:0] HALF      = ONES_W'(VOTES / 2);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARM     = 3'd1,
    SAMPLE  = 3'd2,
    GAP     = 3'd3,
    RESOLVE = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t              state;
  logic                pend;      // start accepted, ARM entered on the following edge
  logic [MEAS_W-1:0]   meas_cnt;
  logic [VOTE_W-1:0]   vote_idx;
  logic [BIT_W-1:0]    bit_idx;
  logic [ONES_W-1:0]   ones_cnt;
  logic                sync1;
  logic                sync2;

  // Two-flop synchronizer: the PUF output is free-running relative to clk
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= puf_response;
      sync2 <= sync1;
    end
  end

  // Collection sequencer with registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      pend          <= 1'b0;
      meas_cnt      <= '0;
      vote_idx      <= '0;
      bit_idx       <= '0;
      ones_cnt      <= '0;
      puf_enable    <= 1'b0;
      puf_challenge <= 2'd0;
      busy          <= 1'b0;
      key_valid     <= 1'b0;
      key           <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pend) begin
            // Launch the first measurement of bit 0
            pend          <= 1'b0;
            state         <= ARM;
            busy          <= 1'b1;
            puf_enable    <= 1'b1;
            puf_challenge <= 2'(bit_idx);
            meas_cnt      <= '0;
          end else if (start) begin
            pend      <= 1'b1;
            key       <= '0;
            key_valid <= 1'b0;
            bit_idx   <= '0;
            vote_idx  <= '0;
            ones_cnt  <= '0;
          end
        end

        ARM: begin
          if (meas_cnt == LAST_MEAS) begin
            state      <= SAMPLE;
            puf_enable <= 1'b0;
          end else begin
            meas_cnt <= meas_cnt + 1'b1;
          end
        end

        SAMPLE: begin
          // sync2 now carries the level the PUF presented late in the ARM window
          ones_cnt <= ones_cnt + ONES_W'(sync2);
          state    <= GAP;
        end

        GAP: begin
          if (vote_idx != LAST_VOTE) begin
            vote_idx   <= vote_idx + 1'b1;
            state      <= ARM;
            puf_enable <= 1'b1;
            meas_cnt   <= '0;
          end else begin
            state <= RESOLVE;
          end
        end

        RESOLVE: begin
          key[bit_idx] <= (ones_cnt > HALF);
          ones_cnt     <= '0;
          vote_idx     <= '0;
          if (bit_idx == LAST_BIT) begin
            state     <= DONE;
            busy      <= 1'b0;
            key_valid <= 1'b1;
          end else begin
            // Challenge follows the bit index modulo 4
            bit_idx       <= bit_idx + 1'b1;
            puf_challenge <= 2'(bit_idx + 1'b1);
            state         <= ARM;
            puf_enable    <= 1'b1;
            meas_cnt      <= '0;
          end
        end

        DONE: begin
          if (start) begin
            pend      <= 1'b1;
            state     <= IDLE;
            key       <= '0;
            key_valid <= 1'b0;
            bit_idx   <= '0;
            vote_idx  <= '0;
            ones_cnt  <= '0;
          end
        end

        default: begin
          state      <= IDLE;
          puf_enable <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_puf_key_collector.sv
// Bench for puf_key_collector: two instances (4 bits / 3 votes and 6 bits / 1 vote, 8-cycle windows)
// checked every cycle against a timeline model, plus hand-computed keys, latencies and challenge orders.
module tb_puf_key_collector;

  localparam int M = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  int         tsel = 0;
  logic       resp [2] = '{1'b0, 1'b0};
  logic       en [2];
  logic [1:0] ch [2];
  logic       busy [2];
  logic       kv [2];
  logic [3:0] key_a;
  logic [5:0] key_b;

  always #5 clk = ~clk;

  puf_key_collector #(.KEY_BITS(4), .MEAS_CYCLES(M), .VOTES(3)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .puf_response(resp[0]),
    .puf_enable(en[0]), .puf_challenge(ch[0]), .busy(busy[0]),
    .key_valid(kv[0]), .key(key_a)
  );

  puf_key_collector #(.KEY_BITS(6), .MEAS_CYCLES(M), .VOTES(1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .puf_response(resp[1]),
    .puf_enable(en[1]), .puf_challenge(ch[1]), .busy(busy[1]),
    .key_valid(kv[1]), .key(key_b)
  );

  // Response tables: bit (challenge*3 + vote) is the PUF level for that measurement
  logic [11:0] tbl [2][2];
  initial begin
    tbl[0][0] = 12'hFD5;  // ch0:1,0,1 ch1:0,1,0 ch2:1,1,1 ch3:1,1,1
    tbl[0][1] = 12'hA1C;  // ch0:0,0,1 ch1:1,1,0 ch2:0,0,0 ch3:1,0,1
    tbl[1][0] = 12'h201;  // ch0=1 ch1=0 ch2=0 ch3=1
    tbl[1][1] = 12'h048;  // ch0=0 ch1=1 ch2=1 ch3=0
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  bit active [2] = '{0, 0};
  int off [2]    = '{0, 0};
  int tsm [2]    = '{0, 0};
  int ch0m [2]   = '{0, 0};

  function automatic int kb(input int d); return (d == 0) ? 4 : 6; endfunction
  function automatic int vt(input int d); return (d == 0) ? 3 : 1; endfunction
  function automatic int pb(input int d); return vt(d) * (M + 2) + 1; endfunction
  function automatic int tt(input int d); return 1 + kb(d) * pb(d); endfunction

  function automatic int resp_of(input int d, input int ts, input int c, input int v);
    logic [11:0] row;
    row = tbl[d][ts];
    return int'(row[c*3 + v]);
  endfunction

  // Key formed from the first nb bits by majority vote over the table
  function automatic int exp_key(input int d, input int ts, input int nb);
    int k, ones;
    k = 0;
    for (int b = 0; b < nb; b++) begin
      ones = 0;
      for (int v = 0; v < vt(d); v++) ones += resp_of(d, ts, b % 4, v);
      if (ones > vt(d) / 2) k |= (1 << b);
    end
    return k;
  endfunction

  task automatic expect_now(input int d, output int e_en, output int e_busy,
                            output int e_kv, output int e_ch, output int e_key);
    int n, t, b, r;
    n = off[d];
    e_en = 0; e_busy = 0; e_kv = 0; e_key = 0; e_ch = ch0m[d];
    if (active[d] && n >= tt(d)) begin
      e_kv  = 1;
      e_key = exp_key(d, tsm[d], kb(d));
      e_ch  = (kb(d) - 1) % 4;
    end else if (active[d] && n >= 1) begin
      t = n - 1;
      b = t / pb(d);
      r = t % pb(d);
      e_busy = 1;
      e_ch   = b % 4;
      e_key  = exp_key(d, tsm[d], b);
      e_en   = (r < vt(d) * (M + 2) && (r % (M + 2)) < M) ? 1 : 0;
    end
  endtask

  // Model timeline advance and start acceptance
  always @(posedge clk or negedge rst_n) begin
    int x_en, x_busy, x_kv, x_ch, x_key;
    if (!rst_n) begin
      for (int d = 0; d < 2; d++) begin
        active[d] <= 1'b0;
        off[d]    <= 0;
        ch0m[d]   <= 0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        expect_now(d, x_en, x_busy, x_kv, x_ch, x_key);
        if (start && x_busy == 0) begin
          active[d] <= 1'b1;
          off[d]    <= 0;
          ch0m[d]   <= x_ch;
          tsm[d]    <= tsel;
        end else if (active[d]) begin
          off[d] <= off[d] + 1;
        end
      end
    end
  end

  // ---------------- compare / stimulus-response process ----------------
  bit p_en [2] = '{0, 0};
  bit p_kv [2] = '{0, 0};
  int run_len [2] = '{0, 0};
  int rise [2] = '{-1, -1};
  int chq0 [$];
  int chq1 [$];

  always @(negedge clk) begin
    int e_en, e_busy, e_kv, e_ch, e_key, a_key, n, t, b, r;
    for (int d = 0; d < 2; d++) begin
      expect_now(d, e_en, e_busy, e_kv, e_ch, e_key);
      a_key = (d == 0) ? int'(key_a) : int'(key_b);
      chk($sformatf("enable_d%0d_off%0d", d, off[d]), int'(en[d]), e_en);
      chk($sformatf("busy_d%0d_off%0d", d, off[d]), int'(busy[d]), e_busy);
      chk($sformatf("key_valid_d%0d_off%0d", d, off[d]), int'(kv[d]), e_kv);
      chk($sformatf("challenge_d%0d_off%0d", d, off[d]), int'(ch[d]), e_ch);
      chk($sformatf("key_d%0d_off%0d", d, off[d]), a_key, e_key);

      // Present the PUF level for the measurement the timeline says is running
      n = off[d];
      if (active[d] && n >= 1 && n < tt(d)) begin
        t = n - 1;
        b = t / pb(d);
        r = t % pb(d);
        if (r < vt(d) * (M + 2)) resp[d] = resp_of(d, tsm[d], b % 4, r / (M + 2)) != 0;
      end

      // Enable pulse bookkeeping
      if (en[d] && !p_en[d]) begin
        if (d == 0) chq0.push_back(int'(ch[d])); else chq1.push_back(int'(ch[d]));
        run_len[d] = 1;
      end else if (en[d]) begin
        run_len[d]++;
      end else if (p_en[d] && active[d]) begin
        chk($sformatf("pulse_width_d%0d", d), run_len[d], M);
      end
      p_en[d] = en[d];
      if (kv[d] && !p_kv[d] && rise[d] < 0) rise[d] = off[d];
      p_kv[d] = kv[d];
    end
  end

  task automatic clear_trk();
    rise[0] = -1;
    rise[1] = -1;
    chq0.delete();
    chq1.delete();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    int seq_a [12];
    int seq_b [6];
    seq_a = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3};
    seq_b = '{0, 1, 2, 3, 0, 1};

    repeat (3) @(negedge clk);
    chk("reset_enable", int'(en[0]), 0);
    chk("reset_busy", int'(busy[0]), 0);
    chk("reset_key_valid", int'(kv[0]), 0);
    chk("reset_key", int'(key_a), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Nominal collection with a start pulse during ARM of bit 2 that must be ignored
    tsel = 0;
    clear_trk();
    pulse_start();
    repeat (64) @(negedge clk);
    pulse_start();
    repeat (70) @(negedge clk);
    chk("run1_key_a", int'(key_a), 4'b1101);
    chk("run1_key_a_bit0_majority", int'(key_a[0]), 1);
    chk("run1_key_a_bit1_majority", int'(key_a[1]), 0);
    chk("run1_rise_a", rise[0], 125);
    chk("run1_pulses_a", chq0.size(), 12);
    for (int i = 0; i < 12; i++) chk($sformatf("run1_chseq_a_%0d", i), (i < chq0.size()) ? chq0[i] : -1, seq_a[i]);
    chk("run1_key_b", int'(key_b), 6'b011001);
    chk("run1_rise_b", rise[1], 67);
    chk("run1_pulses_b", chq1.size(), 6);
    for (int i = 0; i < 6; i++) chk($sformatf("run1_chseq_b_%0d", i), (i < chq1.size()) ? chq1[i] : -1, seq_b[i]);

    // Restart from DONE with a different response table
    tsel = 1;
    clear_trk();
    pulse_start();
    chk("restart_key_valid", int'(kv[0]), 0);
    chk("restart_key", int'(key_a), 0);
    repeat (130) @(negedge clk);
    chk("run2_key_a", int'(key_a), 4'b1010);
    chk("run2_rise_a", rise[0], 125);
    chk("run2_key_b", int'(key_b), 6'b100110);
    chk("run2_rise_b", rise[1], 67);

    // Asynchronous reset in the middle of bit 2, then a fresh collection
    tsel = 0;
    clear_trk();
    pulse_start();
    repeat (70) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_enable", int'(en[0]), 0);
    chk("midrst_busy", int'(busy[0]), 0);
    chk("midrst_key_valid", int'(kv[0]), 0);
    chk("midrst_key", int'(key_a), 0);
    chk("midrst_challenge", int'(ch[0]), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    clear_trk();
    pulse_start();
    repeat (130) @(negedge clk);
    chk("run3_key_a", int'(key_a), 4'b1101);
    chk("run3_rise_a", rise[0], 125);
    chk("run3_pulses_a", chq0.size(), 12);
    chk("run3_key_b", int'(key_b), 6'b011001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
